// File: rtl/branch_cond_unit_pkg.sv
// -----------------------------------------------------------------------------
// branch_cond_unit_pkg
// Shared definitions for the branch condition unit:
//   - branch condition-code encodings (NEQ..UNC)
//   - redirect FSM state encodings
//   - bit positions of N, Z and V inside the 3-bit flag vector
//   - helper to sign-extend the 9-bit branch offset to the 16-bit PC width
// No ports (package).
// -----------------------------------------------------------------------------
package branch_cond_unit_pkg;

  // Branch condition codes as they appear on br_cond.
  typedef enum logic [2:0] {
    CondNeq  = 3'b000,  // Z = 0
    CondEq   = 3'b001,  // Z = 1
    CondGt   = 3'b010,  // Z = 0 and N = 0
    CondLt   = 3'b011,  // N = 1
    CondGte  = 3'b100,  // Z = 1, or Z = 0 and N = 0
    CondLte  = 3'b101,  // N = 1 or Z = 1
    CondOvfl = 3'b110,  // V = 1
    CondUnc  = 3'b111   // always
  } brCond_t;

  // Redirect FSM states.
  typedef enum logic [1:0] {
    StIdle     = 2'b00,
    StRedirect = 2'b01,
    StFlush    = 2'b10
  } fsmState_t;

  // Flag vector layout {N, Z, V}.
  localparam int FlagN = 2;
  localparam int FlagZ = 1;
  localparam int FlagV = 0;

  localparam int PcWidth     = 16;
  localparam int OffsetWidth = 9;

  // Sign-extend the branch offset to PC width.
  function automatic logic [PcWidth-1:0] signExtOffset(input logic [OffsetWidth-1:0] off);
    return {{(PcWidth-OffsetWidth){off[OffsetWidth-1]}}, off};
  endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// -----------------------------------------------------------------------------
// branch_cond_eval
// Purely combinational branch condition evaluator.
// Ports:
//   brCond  in  3  condition code (see brCond_t)
//   flags   in  3  flag vector {N, Z, V}
//   taken   out 1  1 when the condition holds for the given flags
// -----------------------------------------------------------------------------
module branch_cond_eval
  import branch_cond_unit_pkg::*;
(
  input  logic [2:0] brCond,
  input  logic [2:0] flags,
  output logic       taken
);

  logic flagN;
  logic flagZ;
  logic flagV;

  assign flagN = flags[FlagN];
  assign flagZ = flags[FlagZ];
  assign flagV = flags[FlagV];

  always_comb begin
    taken = 1'b0;
    case (brCond)
      CondNeq:  taken = ~flagZ;
      CondEq:   taken = flagZ;
      CondGt:   taken = ~flagZ & ~flagN;
      CondLt:   taken = flagN;
      CondGte:  taken = flagZ | (~flagZ & ~flagN);
      CondLte:  taken = flagN | flagZ;
      CondOvfl: taken = flagV;
      CondUnc:  taken = 1'b1;
      default:  taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_cond_unit.sv
// -----------------------------------------------------------------------------
// branch_cond_unit
// Branch resolution: flag register, flag forwarding, target adder and a small
// redirect/flush FSM.
// Parameters:
//   FLUSH_CYCLES  cycles flush stays high after a taken branch (1..3),
//                 counting the redirect cycle itself.
// Ports:
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   alu_n/z/v    in   1   ALU flags of the current cycle
//   flags_we     in   1   latch ALU flags into the flag register
//   stall        in   1   freeze everything while high
//   br_valid     in   1   branch presented this cycle
//   br_cond      in   3   condition code
//   br_pc_plus1  in   16  address following the branch
//   br_offset    in   9   signed branch offset
//   flags_out    out  3   registered flags {N,Z,V}
//   take         out  1   registered redirect strobe
//   target       out  16  registered redirect address
//   flush        out  1   squash strobe for younger instructions
// -----------------------------------------------------------------------------
module branch_cond_unit
  import branch_cond_unit_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        alu_n,
  input  logic        alu_z,
  input  logic        alu_v,
  input  logic        flags_we,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [2:0]  br_cond,
  input  logic [15:0] br_pc_plus1,
  input  logic [8:0]  br_offset,
  output logic [2:0]  flags_out,
  output logic        take,
  output logic [15:0] target,
  output logic        flush
);

  // Remaining FLUSH-state cycles loaded on a taken branch; the redirect
  // cycle itself accounts for one of the FLUSH_CYCLES.
  localparam logic [1:0] FlushInit = 2'(FLUSH_CYCLES - 1);

  fsmState_t   stateReg,  stateNext;
  logic [1:0]  cntReg,    cntNext;
  logic [2:0]  flagsReg,  flagsNext;
  logic        takeReg,   takeNext;
  logic        flushReg,  flushNext;
  logic [15:0] targetReg, targetNext;

  logic [2:0]  aluFlags;
  logic [2:0]  evalFlags;
  logic [15:0] branchTarget;
  logic        condTrue;

  assign aluFlags = {alu_n, alu_z, alu_v};

  // A flag-setting instruction in the same cycle as the branch is older than
  // the branch, so its flags must be seen before they reach the register.
  assign evalFlags = (flags_we && br_valid) ? aluFlags : flagsReg;

  // 16-bit add wraps naturally.
  assign branchTarget = br_pc_plus1 + signExtOffset(br_offset);

  branch_cond_eval uEval (
    .brCond (br_cond),
    .flags  (evalFlags),
    .taken  (condTrue)
  );

  always_comb begin
    stateNext  = stateReg;
    cntNext    = cntReg;
    flagsNext  = flagsReg;
    takeNext   = takeReg;
    flushNext  = flushReg;
    targetNext = targetReg;

    if (!stall) begin
      // Flag writes from squashed instructions are dropped.
      if (flags_we && !flushReg) begin
        flagsNext = aluFlags;
      end

      takeNext  = 1'b0;
      flushNext = 1'b0;

      case (stateReg)
        StIdle: begin
          if (br_valid && condTrue) begin
            stateNext  = StRedirect;
            cntNext    = FlushInit;
            targetNext = branchTarget;
            takeNext   = 1'b1;
            flushNext  = 1'b1;
          end
        end

        StRedirect: begin
          if (cntReg != 2'd0) begin
            stateNext = StFlush;
            flushNext = 1'b1;
          end else begin
            stateNext = StIdle;
          end
        end

        StFlush: begin
          cntNext = cntReg - 2'd1;
          if (cntReg <= 2'd1) begin
            stateNext = StIdle;
          end else begin
            flushNext = 1'b1;
          end
        end

        default: begin
          stateNext = StIdle;
          cntNext   = 2'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stateReg  <= StIdle;
      cntReg    <= 2'd0;
      flagsReg  <= 3'b000;
      takeReg   <= 1'b0;
      flushReg  <= 1'b0;
      targetReg <= 16'h0000;
    end else begin
      stateReg  <= stateNext;
      cntReg    <= cntNext;
      flagsReg  <= flagsNext;
      takeReg   <= takeNext;
      flushReg  <= flushNext;
      targetReg <= targetNext;
    end
  end

  assign flags_out = flagsReg;
  assign take      = takeReg;
  assign target    = targetReg;
  assign flush     = flushReg;

endmodule

// File: tb/tb_branch_cond_unit.sv
// -----------------------------------------------------------------------------
// tb_branch_cond_unit
// Directed self-checking bench for branch_cond_unit (FLUSH_CYCLES = 2).
// -----------------------------------------------------------------------------
module tb_branch_cond_unit;

  logic        clk;
  logic        rst_n;
  logic        alu_n;
  logic        alu_z;
  logic        alu_v;
  logic        flags_we;
  logic        stall;
  logic        br_valid;
  logic [2:0]  br_cond;
  logic [15:0] br_pc_plus1;
  logic [8:0]  br_offset;
  logic [2:0]  flags_out;
  logic        take;
  logic [15:0] target;
  logic        flush;

  int nCompared;
  int nMismatched;

  branch_cond_unit #(.FLUSH_CYCLES(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .alu_n       (alu_n),
    .alu_z       (alu_z),
    .alu_v       (alu_v),
    .flags_we    (flags_we),
    .stall       (stall),
    .br_valid    (br_valid),
    .br_cond     (br_cond),
    .br_pc_plus1 (br_pc_plus1),
    .br_offset   (br_offset),
    .flags_out   (flags_out),
    .take        (take),
    .target      (target),
    .flush       (flush)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    nCompared++;
    assert (obs === exp)
    else begin
      nMismatched++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkOuts(input string tag, input logic expTake, input logic expFlush,
                           input logic [15:0] expTarget);
    check({tag, ".take"},   {15'd0, take},  {15'd0, expTake});
    check({tag, ".flush"},  {15'd0, flush}, {15'd0, expFlush});
    check({tag, ".target"}, target,         expTarget);
    $display("step %-12s take=%0b flush=%0b target=%h flags=%b", tag, take, flush, target, flags_out);
  endtask

  task automatic writeFlags(input logic [2:0] f);
    flags_we = 1'b1;
    {alu_n, alu_z, alu_v} = f;
    tick();
    flags_we = 1'b0;
    check("flagsWrite", {13'd0, flags_out}, {13'd0, f});
  endtask

  // Present one branch with stored flags; if taken, walk through the flush.
  task automatic branchStep(input string tag, input logic [2:0] cond, input logic [15:0] pc,
                            input logic [8:0] off, input logic expTake, input logic [15:0] expTarget);
    br_valid    = 1'b1;
    br_cond     = cond;
    br_pc_plus1 = pc;
    br_offset   = off;
    tick();
    br_valid = 1'b0;
    checkOuts(tag, expTake, expTake, expTarget);
    if (take) begin
      tick();
      checkOuts({tag, ".fl"}, 1'b0, 1'b1, expTarget);
      tick();
      checkOuts({tag, ".idle"}, 1'b0, 1'b0, expTarget);
    end
  endtask

  initial begin
    nCompared   = 0;
    nMismatched = 0;
    rst_n       = 1'b0;
    {alu_n, alu_z, alu_v} = 3'b000;
    flags_we    = 1'b0;
    stall       = 1'b0;
    br_valid    = 1'b0;
    br_cond     = 3'b000;
    br_pc_plus1 = 16'h0000;
    br_offset   = 9'h000;

    // Reset state
    tick();
    tick();
    checkOuts("reset", 1'b0, 1'b0, 16'h0000);
    check("resetFlags", {13'd0, flags_out}, 16'h0000);
    rst_n = 1'b1;

    // Flags update then branch (EQ with Z=1)
    writeFlags(3'b010);
    branchStep("flagsThenEq", 3'b001, 16'h0010, 9'h005, 1'b1, 16'h0015);

    // Forwarding: EQ sees alu_z=1 in the same cycle
    writeFlags(3'b000);
    flags_we = 1'b1; {alu_n, alu_z, alu_v} = 3'b010;
    branchStep("fwdEq", 3'b001, 16'h0100, 9'h010, 1'b1, 16'h0110);
    flags_we = 1'b0;

    // Forwarding: NEQ sees alu_z=1, not stored Z=0
    writeFlags(3'b000);
    flags_we = 1'b1; {alu_n, alu_z, alu_v} = 3'b010;
    branchStep("fwdNeq", 3'b000, 16'h0200, 9'h020, 1'b0, 16'h0110);
    flags_we = 1'b0;
    check("fwdNeqFlags", {13'd0, flags_out}, 16'h0002);

    // Condition codes with stored flags N=0 Z=1 V=0
    branchStep("gtZ1",   3'b010, 16'h0300, 9'h001, 1'b0, 16'h0110);
    branchStep("gteZ1",  3'b100, 16'h0300, 9'h002, 1'b1, 16'h0302);
    branchStep("lteZ1",  3'b101, 16'h0300, 9'h003, 1'b1, 16'h0303);
    branchStep("ovflV0", 3'b110, 16'h0300, 9'h004, 1'b0, 16'h0303);

    // N=1 Z=0 V=1
    writeFlags(3'b101);
    branchStep("neqZ0",  3'b000, 16'h0300, 9'h005, 1'b1, 16'h0305);
    branchStep("eqZ0",   3'b001, 16'h0300, 9'h006, 1'b0, 16'h0305);
    branchStep("ltN1",   3'b011, 16'h0300, 9'h007, 1'b1, 16'h0307);
    branchStep("gteN1",  3'b100, 16'h0300, 9'h008, 1'b0, 16'h0307);
    branchStep("ovflV1", 3'b110, 16'h0300, 9'h009, 1'b1, 16'h0309);

    // N=0 Z=0 V=0
    writeFlags(3'b000);
    branchStep("gt000",  3'b010, 16'h0300, 9'h00A, 1'b1, 16'h030A);
    branchStep("lt000",  3'b011, 16'h0300, 9'h00B, 1'b0, 16'h030A);

    // Target arithmetic
    branchStep("wrap",   3'b111, 16'hFFFE, 9'h003, 1'b1, 16'h0001);
    branchStep("negOff", 3'b111, 16'h0002, 9'h1FC, 1'b1, 16'hFFFE);

    // Squash: branches and flag writes during REDIRECT/FLUSH are ignored
    br_valid = 1'b1; br_cond = 3'b111; br_pc_plus1 = 16'h1000; br_offset = 9'h000;
    tick();
    checkOuts("sqRedirect", 1'b1, 1'b1, 16'h1000);
    br_pc_plus1 = 16'h2000;
    flags_we = 1'b1; {alu_n, alu_z, alu_v} = 3'b111;
    tick();
    checkOuts("sqFlush", 1'b0, 1'b1, 16'h1000);
    check("sqFlagsA", {13'd0, flags_out}, 16'h0000);
    tick();
    checkOuts("sqIdle", 1'b0, 1'b0, 16'h1000);
    check("sqFlagsB", {13'd0, flags_out}, 16'h0000);
    br_valid = 1'b0; flags_we = 1'b0;

    // Stall in IDLE blocks both the branch and the flag write
    stall = 1'b1;
    br_valid = 1'b1; br_cond = 3'b111; br_pc_plus1 = 16'h4000; br_offset = 9'h000;
    flags_we = 1'b1; {alu_n, alu_z, alu_v} = 3'b111;
    tick();
    checkOuts("stallIdle", 1'b0, 1'b0, 16'h1000);
    check("stallFlags", {13'd0, flags_out}, 16'h0000);
    flags_we = 1'b0;
    stall = 1'b0;
    tick();
    checkOuts("stRedirect", 1'b1, 1'b1, 16'h4000);
    br_valid = 1'b0;
    tick();
    checkOuts("stFlush", 1'b0, 1'b1, 16'h4000);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOuts("stHeld", 1'b0, 1'b1, 16'h4000);
    end
    stall = 1'b0;
    tick();
    checkOuts("stDone", 1'b0, 1'b0, 16'h4000);

    // Reset asserted between edges while in FLUSH
    writeFlags(3'b111);
    br_valid = 1'b1; br_cond = 3'b111; br_pc_plus1 = 16'h5000; br_offset = 9'h000;
    tick();
    br_valid = 1'b0;
    checkOuts("rstRedirect", 1'b1, 1'b1, 16'h5000);
    tick();
    checkOuts("rstFlush", 1'b0, 1'b1, 16'h5000);
    #2;
    rst_n = 1'b0;
    #1;
    checkOuts("rstAsync", 1'b0, 1'b0, 16'h0000);
    check("rstFlags", {13'd0, flags_out}, 16'h0000);
    rst_n = 1'b1;

    // First branch after reset behaves normally
    branchStep("postRst", 3'b111, 16'h0020, 9'h1FF, 1'b1, 16'h001F);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
